// File: rtl/eee_colour_bbox_if.sv
// Pixel stream link carrying {R,G,B} beats with valid/ready flow control and packet framing.
// The producer drives data/valid/sop/eop and the consumer drives ready.
interface eee_colour_bbox_if;
   logic [23:0] data;
   logic        valid;
   logic        ready;
   logic        sop;
   logic        eop;

   modport master (output data, output valid, output sop, output eop, input ready);
   modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/eee_colour_bbox.sv
// Colour bounding-box tracker: finds pixels equal to target_col, publishes their per-frame box, overlays the previous box.
// Optional feature macro BBOX_MINCOUNT_EN: a box is only reported as found when at least MIN_PIXELS pixels matched.
module eee_colour_bbox #(
   parameter logic [10:0] IMAGE_W    = 11'd640,
   parameter logic [10:0] IMAGE_H    = 11'd480
`ifdef BBOX_MINCOUNT_EN
   ,
   parameter logic [15:0] MIN_PIXELS = 16'd16
`endif
) (
   input  logic                    clk,
   input  logic                    reset_n,
   eee_colour_bbox_if.slave        sink,
   eee_colour_bbox_if.master       source,
   input  logic [23:0]             target_col,
   input  logic [23:0]             bb_col,
   input  logic                    mode,
   output logic [10:0]             bbox_left,
   output logic [10:0]             bbox_right,
   output logic [10:0]             bbox_top,
   output logic [10:0]             bbox_bottom,
   output logic                    bbox_found,
   output logic                    bbox_strobe
);

   logic        sink_ready_s;
   logic        accept_s;
   logic        sop_beat_s;
   logic        data_beat_s;
   logic        match_s;
   logic        eof_s;
   logic        found_s;
   logic        on_vert_s;
   logic        on_horz_s;
   logic [23:0] pix_s;

   logic [23:0] src_data_q;
   logic        src_valid_q;
   logic        src_sop_q;
   logic        src_eop_q;

   logic        packet_video_q, packet_video_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [10:0] min_x_q, min_x_d;
   logic [10:0] max_x_q, max_x_d;
   logic [10:0] min_y_q, min_y_d;
   logic [10:0] max_y_q, max_y_d;
   logic        hit_q, hit_d;

   logic [10:0] bbox_left_q, bbox_left_d;
   logic [10:0] bbox_right_q, bbox_right_d;
   logic [10:0] bbox_top_q, bbox_top_d;
   logic [10:0] bbox_bottom_q, bbox_bottom_d;
   logic        bbox_found_q;
   logic        bbox_strobe_q;

   assign sink_ready_s = ~src_valid_q | source.ready;
   assign sink.ready   = sink_ready_s;
   assign accept_s     = sink.valid & sink_ready_s;
   assign sop_beat_s   = accept_s & sink.sop;
   assign data_beat_s  = accept_s & ~sink.sop & packet_video_q;
   assign match_s      = data_beat_s & (sink.data == target_col);
   assign eof_s        = data_beat_s & sink.eop;

   assign source.data  = src_data_q;
   assign source.valid = src_valid_q;
   assign source.sop   = src_sop_q;
   assign source.eop   = src_eop_q;

   assign bbox_left    = bbox_left_q;
   assign bbox_right   = bbox_right_q;
   assign bbox_top     = bbox_top_q;
   assign bbox_bottom  = bbox_bottom_q;
   assign bbox_found   = bbox_found_q;
   assign bbox_strobe  = bbox_strobe_q;

   // Raster position and match accumulators; an SOP re-arms everything and drops any unfinished frame
   always_comb begin
      packet_video_d = packet_video_q;
      x_d            = x_q;
      y_d            = y_q;
      min_x_d        = min_x_q;
      max_x_d        = max_x_q;
      min_y_d        = min_y_q;
      max_y_d        = max_y_q;
      hit_d          = hit_q;
      if (sop_beat_s) begin
         packet_video_d = (sink.data[3:0] == 4'd0);
         x_d            = 11'd0;
         y_d            = 11'd0;
         min_x_d        = 11'h7FF;
         max_x_d        = 11'd0;
         min_y_d        = 11'h7FF;
         max_y_d        = 11'd0;
         hit_d          = 1'b0;
      end else if (data_beat_s) begin
         if (x_q == IMAGE_W - 11'd1) begin
            x_d = 11'd0;
            if (y_q >= IMAGE_H - 11'd1) begin
               y_d = y_q;
            end else begin
               y_d = y_q + 11'd1;
            end
         end else begin
            x_d = x_q + 11'd1;
            y_d = y_q;
         end
         if (match_s) begin
            min_x_d = (x_q < min_x_q) ? x_q : min_x_q;
            max_x_d = (x_q > max_x_q) ? x_q : max_x_q;
            min_y_d = (y_q < min_y_q) ? y_q : min_y_q;
            max_y_d = (y_q > max_y_q) ? y_q : max_y_q;
            hit_d   = 1'b1;
         end else begin
            hit_d   = hit_q;
         end
      end else begin
         hit_d = hit_q;
      end
   end

`ifdef BBOX_MINCOUNT_EN
   logic [15:0] count_q, count_d;

   // Saturating match counter, only meaningful together with hit
   always_comb begin
      if (sop_beat_s) begin
         count_d = 16'd0;
      end else if (match_s && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Match counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign found_s = hit_d & (count_d >= MIN_PIXELS);
`else
   assign found_s = hit_d;
`endif

   // Box published at end of frame includes the EOP pixel itself; an unfound box reports zero coordinates
   always_comb begin
      if (found_s) begin
         bbox_left_d   = min_x_d;
         bbox_right_d  = max_x_d;
         bbox_top_d    = min_y_d;
         bbox_bottom_d = max_y_d;
      end else begin
         bbox_left_d   = 11'd0;
         bbox_right_d  = 11'd0;
         bbox_top_d    = 11'd0;
         bbox_bottom_d = 11'd0;
      end
   end

   // Overlay draws the latched previous-frame box; detection above always sees the raw input
   always_comb begin
      on_vert_s = ((x_q == bbox_left_q) | (x_q == bbox_right_q)) &
                  (y_q >= bbox_top_q) & (y_q <= bbox_bottom_q);
      on_horz_s = ((y_q == bbox_top_q) | (y_q == bbox_bottom_q)) &
                  (x_q >= bbox_left_q) & (x_q <= bbox_right_q);
      if (mode & packet_video_q & ~sink.sop & bbox_found_q & (on_vert_s | on_horz_s)) begin
         pix_s = bb_col;
      end else begin
         pix_s = sink.data;
      end
   end

   // Output register stage, tracking state and latched box
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_data_q     <= 24'd0;
         src_valid_q    <= 1'b0;
         src_sop_q      <= 1'b0;
         src_eop_q      <= 1'b0;
         packet_video_q <= 1'b0;
         x_q            <= 11'd0;
         y_q            <= 11'd0;
         min_x_q        <= 11'd0;
         max_x_q        <= 11'd0;
         min_y_q        <= 11'd0;
         max_y_q        <= 11'd0;
         hit_q          <= 1'b0;
         bbox_left_q    <= 11'd0;
         bbox_right_q   <= 11'd0;
         bbox_top_q     <= 11'd0;
         bbox_bottom_q  <= 11'd0;
         bbox_found_q   <= 1'b0;
         bbox_strobe_q  <= 1'b0;
      end else begin
         if (accept_s) begin
            src_data_q  <= pix_s;
            src_valid_q <= 1'b1;
            src_sop_q   <= sink.sop;
            src_eop_q   <= sink.eop;
         end else if (source.ready) begin
            src_valid_q <= 1'b0;
         end else begin
            src_valid_q <= src_valid_q;
         end
         packet_video_q <= packet_video_d;
         x_q            <= x_d;
         y_q            <= y_d;
         min_x_q        <= min_x_d;
         max_x_q        <= max_x_d;
         min_y_q        <= min_y_d;
         max_y_q        <= max_y_d;
         hit_q          <= hit_d;
         bbox_strobe_q  <= eof_s;
         if (eof_s) begin
            bbox_left_q   <= bbox_left_d;
            bbox_right_q  <= bbox_right_d;
            bbox_top_q    <= bbox_top_d;
            bbox_bottom_q <= bbox_bottom_d;
            bbox_found_q  <= found_s;
         end else begin
            bbox_found_q  <= bbox_found_q;
         end
      end
   end

endmodule

// File: tb/tb_eee_colour_bbox.sv
// Randomised self-checking bench for eee_colour_bbox on an 8x4 image against a frame-level reference model.
module tb_eee_colour_bbox;
   localparam logic [10:0] W_P  = 11'd8;
   localparam logic [10:0] H_P  = 11'd4;
   localparam int          W    = 8;
   localparam int          H    = 4;
   localparam logic [23:0] GREY = 24'h808080;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] target_col;
   logic [23:0] bb_col;
   logic        mode;
   logic [10:0] bbox_left, bbox_right, bbox_top, bbox_bottom;
   logic        bbox_found, bbox_strobe;

   eee_colour_bbox_if sink_if ();
   eee_colour_bbox_if source_if ();

   always #5 clk = ~clk;

   eee_colour_bbox #(
      .IMAGE_W(W_P),
      .IMAGE_H(H_P)
`ifdef BBOX_MINCOUNT_EN
      ,
      .MIN_PIXELS(16'd3)
`endif
   ) dut (
      .clk(clk), .reset_n(reset_n), .sink(sink_if), .source(source_if),
      .target_col(target_col), .bb_col(bb_col), .mode(mode),
      .bbox_left(bbox_left), .bbox_right(bbox_right), .bbox_top(bbox_top),
      .bbox_bottom(bbox_bottom), .bbox_found(bbox_found), .bbox_strobe(bbox_strobe)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit          m_video;
   int          m_idx;
   int          mx[$];
   int          my[$];
   bit          b_found;
   int          b_l, b_r, b_t, b_b;
   bit          strobe_due;
   logic [25:0] exp_q[$];
   logic [25:0] out_log[$];
   bit          stall_prev;
   logic [26:0] held;
   int          rdy_mode;
   bit          rnd_valid;

   task automatic check_value(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit on_box(input int x, input int y);
      return ((x == b_l || x == b_r) && y >= b_t && y <= b_b) ||
             ((y == b_t || y == b_b) && x >= b_l && x <= b_r);
   endfunction

   function automatic logic [44:0] model_box();
      return {b_found, 11'(b_l), 11'(b_r), 11'(b_t), 11'(b_b)};
   endfunction

   task automatic model_reset();
      m_video = 1'b0; m_idx = 0; mx.delete(); my.delete();
      b_found = 1'b0; b_l = 0; b_r = 0; b_t = 0; b_b = 0;
      strobe_due = 1'b0; exp_q.delete(); stall_prev = 1'b0;
   endtask

   // frame-level behaviour: raster position from beat index, box from the list of matches
   task automatic model_beat(input logic [23:0] d, input bit sop, input bit eop);
      logic [23:0] o;
      int x, y, lx, rx, ty, by;
      bit f;
      o = d;
      if (sop) begin
         m_video = (d[3:0] == 4'd0);
         m_idx = 0; mx.delete(); my.delete();
      end else if (m_video) begin
         x = m_idx % W;
         y = m_idx / W;
         if (y > H - 1) y = H - 1;
         m_idx++;
         if (mode && b_found && on_box(x, y)) o = bb_col;
         if (d == target_col) begin mx.push_back(x); my.push_back(y); end
         if (eop) begin
`ifdef BBOX_MINCOUNT_EN
            f = (mx.size() >= 3);
`else
            f = (mx.size() > 0);
`endif
            lx = 2047; rx = 0; ty = 2047; by = 0;
            foreach (mx[k]) begin
               if (mx[k] < lx) lx = mx[k];
               if (mx[k] > rx) rx = mx[k];
               if (my[k] < ty) ty = my[k];
               if (my[k] > by) by = my[k];
            end
            b_found = f;
            if (f) begin b_l = lx; b_r = rx; b_t = ty; b_b = by; end
            else begin b_l = 0; b_r = 0; b_t = 0; b_b = 0; end
            strobe_due = 1'b1;
         end
      end
      exp_q.push_back({sop, eop, o});
   endtask

   // one clock: called just after a negedge with inputs driven; returns whether the sink beat was taken
   task automatic step(output bit acc);
      logic [25:0] e;
      #1;
      check_value("strobe", bbox_strobe, strobe_due);
      check_value("bbox", {bbox_found, bbox_left, bbox_right, bbox_top, bbox_bottom}, model_box());
      check_value("sink_ready", sink_if.ready, !source_if.valid || source_if.ready);
      strobe_due = 1'b0;
      if (stall_prev)
         check_value("stall_hold", {source_if.valid, source_if.sop, source_if.eop, source_if.data}, held);
      if (source_if.valid && source_if.ready) begin
         check_value("out_expected", 48'(exp_q.size() != 0), 48'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_value("out_beat", {source_if.sop, source_if.eop, source_if.data}, e);
         end
         out_log.push_back({source_if.sop, source_if.eop, source_if.data});
      end
      stall_prev = source_if.valid && !source_if.ready;
      held = {source_if.valid, source_if.sop, source_if.eop, source_if.data};
      acc = sink_if.valid && sink_if.ready;
      if (acc) model_beat(sink_if.data, sink_if.sop, sink_if.eop);
      @(negedge clk);
   endtask

   task automatic drive_ready();
      case (rdy_mode)
         0:       source_if.ready = 1'b1;
         1:       source_if.ready = ~source_if.ready;
         default: source_if.ready = 1'($urandom);
      endcase
   endtask

   task automatic send_beat(input logic [23:0] d, input bit sop, input bit eop);
      bit acc;
      int guard;
      acc = 1'b0; guard = 0;
      while (!acc) begin
         drive_ready();
         if (rnd_valid && $urandom_range(0, 2) == 0) begin
            sink_if.valid = 1'b0; sink_if.data = 24'($urandom);
            sink_if.sop = 1'($urandom); sink_if.eop = 1'($urandom);
         end else begin
            sink_if.valid = 1'b1; sink_if.data = d; sink_if.sop = sop; sink_if.eop = eop;
         end
         step(acc);
         guard++;
         if (guard > 200) begin
            $display("FAIL send_beat: beat not accepted within 200 cycles");
            n_fail++;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "stuck");
         end
      end
      sink_if.valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 100 && (exp_q.size() != 0 || source_if.valid); i++) begin
         sink_if.valid = 1'b0;
         source_if.ready = 1'b1;
         step(acc);
      end
      check_value("drain_empty", 48'(exp_q.size()), 48'd0);
   endtask

   task automatic send_frame(input logic [23:0] sopd, input int npix, input logic [63:0] tmask,
                             input bit rnd_bg, input bit eop_last);
      logic [23:0] px;
      send_beat(sopd, 1'b1, (npix == 0) && eop_last);
      for (int i = 0; i < npix; i++) begin
         if (i < 64 && tmask[i]) px = target_col;
         else if (rnd_bg)        px = 24'($urandom);
         else                    px = GREY;
         send_beat(px, 1'b0, eop_last && (i == npix - 1));
      end
   endtask

   initial begin
      logic [63:0] mask;
      logic [23:0] sopd;
      bit acc;
      sink_if.valid = 1'b0; sink_if.data = 24'd0; sink_if.sop = 1'b0; sink_if.eop = 1'b0;
      source_if.ready = 1'b1;
      target_col = 24'h30C050; bb_col = 24'hFF0000; mode = 1'b0;
      rdy_mode = 0; rnd_valid = 1'b0;
      model_reset();
      out_log.delete();

      @(negedge clk); #1;
      check_value("rst_src_valid", source_if.valid, 48'd0);
      check_value("rst_src_beat", {source_if.sop, source_if.eop, source_if.data}, 48'd0);
      check_value("rst_bbox", {bbox_found, bbox_strobe, bbox_left, bbox_right, bbox_top, bbox_bottom}, 48'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // targets at (2,1) and (5,3)
      mask = 64'd0; mask[10] = 1'b1; mask[29] = 1'b1;
`ifdef BBOX_MINCOUNT_EN
      mask[19] = 1'b1;
`endif
      send_frame(24'h000000, 32, mask, 1'b0, 1'b1);
      drain();
      check_value("t2_box", {bbox_found, bbox_left, bbox_right, bbox_top, bbox_bottom},
                  {1'b1, 11'd2, 11'd5, 11'd1, 11'd3});

      // non-video packet full of target pixels must not disturb the box
      send_frame(24'h00000F, 32, {64{1'b1}}, 1'b0, 1'b1);
      drain();
      check_value("t6_box", {bbox_found, bbox_left, bbox_right, bbox_top, bbox_bottom},
                  {1'b1, 11'd2, 11'd5, 11'd1, 11'd3});

      // overlay of the previous box on a grey frame with no target
      mode = 1'b1;
      out_log.delete();
      send_frame(24'h000000, 32, 64'd0, 1'b0, 1'b1);
      drain();
      check_value("t4_len", 48'(out_log.size()), 48'd33);
      if (out_log.size() == 33) begin
         check_value("t4_sop", out_log[0], {2'b10, 24'h000000});
         check_value("t4_p22", out_log[1 + 2 * W + 2], {2'b00, bb_col});
         check_value("t4_p31", out_log[1 + 1 * W + 3], {2'b00, bb_col});
         check_value("t4_p32", out_log[1 + 2 * W + 3], {2'b00, GREY});
      end
      check_value("t3_box", {bbox_found, bbox_left, bbox_right, bbox_top, bbox_bottom}, 48'd0);
      send_frame(24'h000000, 32, 64'd0, 1'b1, 1'b1);
      drain();

`ifdef BBOX_MINCOUNT_EN
      mask = 64'd0; mask[10] = 1'b1; mask[29] = 1'b1;
      send_frame(24'h000000, 32, mask, 1'b0, 1'b1);
      drain();
      check_value("mincount_found", bbox_found, 48'd0);
`endif

      // randomised frames under backpressure, including oversize, short, SOP+EOP and unfinished frames
      rnd_valid = 1'b1;
      for (int f = 0; f < 24; f++) begin
         rdy_mode = (f < 12) ? 1 : 2;
         mode = 1'($urandom);
         sopd = 24'($urandom);
         if ($urandom_range(0, 3) != 0) sopd[3:0] = 4'd0;
         else sopd[3:0] = 4'($urandom_range(1, 15));
         mask = {$urandom, $urandom} & {$urandom, $urandom};
         send_frame(sopd, $urandom_range(0, 40), mask, 1'($urandom), $urandom_range(0, 4) != 0);
      end
      drain();

      // asynchronous reset in the middle of a frame
      rnd_valid = 1'b0; rdy_mode = 1;
      send_frame(24'h000000, 10, 64'h0000_0000_0000_0300, 1'b0, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      check_value("t1_src_valid", source_if.valid, 48'd0);
      check_value("t1_bbox", {bbox_found, bbox_strobe, bbox_left, bbox_right, bbox_top, bbox_bottom}, 48'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      rdy_mode = 0;
      send_beat(target_col, 1'b0, 1'b1);
      mask = 64'd0; mask[7] = 1'b1; mask[25] = 1'b1; mask[26] = 1'b1;
`ifdef BBOX_MINCOUNT_EN
      mask[12] = 1'b1;
`endif
      send_frame(24'h000000, 32, mask, 1'b1, 1'b1);
      drain();
      check_value("resume_box", {bbox_found, bbox_left, bbox_right, bbox_top, bbox_bottom},
                  {1'b1, 11'd1, 11'd7, 11'd0, 11'd3});

      for (int i = 0; i < 3; i++) begin
         sink_if.valid = 1'b0;
         step(acc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
